layer_reg_scheduler: RTL

//  Owns the ports of one layer-register memory bank (32 x 16b, async read, sync write).

---
 rtl/layer_reg_scheduler_if.sv | 29 ++
 rtl/layer_reg_scheduler.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/layer_reg_scheduler_if.sv
// Host write, compositor scan and layer-register memory signals of layer_reg_scheduler.
// The slave modport is the scheduler; master is the host/compositor/memory side.
interface layer_reg_scheduler_if;
    logic        host_wr_valid;
    logic        host_wr_ready;
    logic [4:0]  host_wr_addr;
    logic [15:0] host_wr_data;
    logic        scan_valid;
    logic [4:0]  scan_addr;
    logic [15:0] scan_data;
    logic        scan_done;
    logic [4:0]  mem_read_addr;
    logic [15:0] mem_read_data;
    logic        mem_write_en;
    logic [4:0]  mem_write_addr;
    logic [15:0] mem_write_data;

    modport master (
        output host_wr_valid, host_wr_addr, host_wr_data, mem_read_data,
        input  host_wr_ready, scan_valid, scan_addr, scan_data, scan_done,
               mem_read_addr, mem_write_en, mem_write_addr, mem_write_data
    );

    modport slave (
        input  host_wr_valid, host_wr_addr, host_wr_data, mem_read_data,
        output host_wr_ready, scan_valid, scan_addr, scan_data, scan_done,
               mem_read_addr, mem_write_en, mem_write_addr, mem_write_data
    );
endinterface

// File: rtl/layer_reg_scheduler.sv
// Layer-register bank owner: vblank-gated host write FIFO, per-frame read scan and,
// when LAYER_REG_CLEAR_EN is defined, a clear engine sharing the single write port.
//
// scan state | meaning
// S_IDLE     | no scan; drain/clear may use the write port
// S_SCAN     | mem_read_addr = idx, one beat registered per cycle
// S_DONE     | last beat on the outputs; write port still stalled
module layer_reg_scheduler #(
    parameter int NUM_LAYERS = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        vblank,
    input  logic                        scan_start,
`ifdef LAYER_REG_CLEAR_EN
    input  logic                        clear_req,
    output logic                        clear_done,
`endif
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    layer_reg_scheduler_if.slave        bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [4:0] LAST = 5'(NUM_LAYERS - 1);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} scan_state_t;

    scan_state_t scan_q, scan_d;
    logic [4:0]  idx_q;
    logic        scan_valid_q, scan_done_q;
    logic [4:0]  scan_addr_q;
    logic [15:0] scan_data_q;

    logic [4:0]  fifo_addr [FIFO_DEPTH];
    logic [15:0] fifo_data [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic        full, empty, push, pop, ready;

    logic        wr_en_q;
    logic [4:0]  wr_addr_q;
    logic [15:0] wr_data_q;

    logic        scan_hold, drain_allow, drain_go, clr_write, clr_busy;
    logic [4:0]  clr_addr;

    // A scan_start being accepted this cycle already blocks the write port.
    assign scan_hold = (scan_q != S_IDLE) || scan_start;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) scan_q <= S_IDLE;
        else        scan_q <= scan_d;
    end

    always_comb begin
        scan_d = scan_q;
        unique case (scan_q)
            S_IDLE: if (scan_start) scan_d = S_SCAN;
            S_SCAN: if (idx_q == LAST) scan_d = S_DONE;
            S_DONE: scan_d = S_IDLE;
            default: scan_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx_q        <= '0;
            scan_valid_q <= 1'b0;
            scan_done_q  <= 1'b0;
            scan_addr_q  <= '0;
            scan_data_q  <= '0;
        end else begin
            idx_q        <= (scan_q == S_SCAN) ? idx_q + 5'd1 : '0;
            scan_valid_q <= (scan_q == S_SCAN);
            scan_done_q  <= (scan_q == S_SCAN) && (idx_q == LAST);
            scan_addr_q  <= (scan_q == S_SCAN) ? idx_q : '0;
            scan_data_q  <= (scan_q == S_SCAN) ? bus.mem_read_data : '0;
        end
    end

    assign full  = (count_q == CW'(FIFO_DEPTH));
    assign empty = (count_q == '0);
    assign push  = bus.host_wr_valid && ready;
    assign pop   = drain_go;
    assign drain_go = vblank && !empty && !scan_hold && drain_allow;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr_q] <= bus.host_wr_addr;
            fifo_data[wr_ptr_q] <= bus.host_wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            unique case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

`ifdef LAYER_REG_CLEAR_EN
    typedef enum logic [1:0] {C_IDLE, C_PEND, C_RUN, C_FIN} clr_state_t;

    clr_state_t clr_q, clr_d;
    logic [4:0] caddr_q;
    logic       clear_done_q;

    assign clr_write   = (clr_q == C_RUN) && vblank && !scan_hold;
    assign clr_busy    = (clr_q != C_IDLE);
    assign drain_allow = (clr_q == C_IDLE) || (clr_q == C_PEND);
    assign clr_addr    = caddr_q;
    assign clear_done  = clear_done_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) clr_q <= C_IDLE;
        else        clr_q <= clr_d;
    end

    always_comb begin
        clr_d = clr_q;
        unique case (clr_q)
            C_IDLE: if (clear_req) clr_d = C_PEND;
            C_PEND: if (vblank && empty && !scan_hold) clr_d = C_RUN;
            C_RUN:  if (clr_write && (caddr_q == LAST)) clr_d = C_FIN;
            C_FIN:  clr_d = C_IDLE;
            default: clr_d = C_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            caddr_q      <= '0;
            clear_done_q <= 1'b0;
        end else begin
            if (clr_q == C_IDLE) caddr_q <= '0;
            else if (clr_write)  caddr_q <= caddr_q + 5'd1;
            clear_done_q <= (clr_q == C_FIN);
        end
    end
`else
    assign clr_write   = 1'b0;
    assign clr_busy    = 1'b0;
    assign drain_allow = 1'b1;
    assign clr_addr    = '0;
`endif

    assign ready = !full && !clr_busy;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            wr_en_q <= 1'b0;
            if (clr_write) begin
                wr_en_q   <= 1'b1;
                wr_addr_q <= clr_addr;
                wr_data_q <= '0;
            end else if (drain_go) begin
                wr_en_q   <= 1'b1;
                wr_addr_q <= fifo_addr[rd_ptr_q];
                wr_data_q <= fifo_data[rd_ptr_q];
            end
        end
    end

    assign bus.host_wr_ready  = ready;
    assign bus.scan_valid     = scan_valid_q;
    assign bus.scan_addr      = scan_addr_q;
    assign bus.scan_data      = scan_data_q;
    assign bus.scan_done      = scan_done_q;
    assign bus.mem_read_addr  = (scan_q == S_SCAN) ? idx_q : '0;
    assign bus.mem_write_en   = wr_en_q;
    assign bus.mem_write_addr = wr_addr_q;
    assign bus.mem_write_data = wr_data_q;
    assign fifo_count         = count_q;
endmodule
